// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling, 8N1 framing with frame-error detection.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (sense set by PARITY_ODD).
module uart_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
   localparam int HALF    = DIVISOR / 2;
   localparam int CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DIVISOR - 1);
   localparam logic [CW-1:0] MID_CNT  = CW'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, rx_s_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic            par_bad_q, par_bad_d;
   logic            perr_q, perr_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == MID_CNT) begin
               // A start bit that is already gone at mid-bit is treated as a glitch.
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = S_DATA;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s_q;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d     = '0;
               par_bad_d = ((^shift_q) ^ rx_s_q) != PARITY_ODD[0];
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_IDLE;
               end
`ifdef UART_RX_PARITY_EN
               else if (par_bad_q) begin
                  perr_d  = 1'b1;
                  state_d = S_IDLE;
               end
`endif
               else begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sync1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         sync1_q   <= rx_serial;
         rx_s_q    <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign rx_busy   = (state_q != S_IDLE);
   assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   logic unused_parity_sense;
   assign unused_parity_sense = PARITY_ODD[0];
   assign parity_err = 1'b0;
`endif

endmodule
